// File: rtl/core_pkg.sv
// Shared fetch-path definitions: exception causes, the canonical NOP and the
// layout of one fetch-queue entry.
package core_pkg;

    localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;
    localparam logic [31:0] NOP_INSTR              = 32'h0000_0013;

    localparam int XLEN       = 64;
    localparam int ILEN       = 32;
    localparam int EXC_CODE_W = 4;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [ILEN-1:0]       instr;
        logic                  exc_en;
        logic [EXC_CODE_W-1:0] exc_code;
        logic [XLEN-1:0]       exc_val;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Value shown on the decode-facing outputs whenever the queue is empty.
    function automatic fetch_entry_t idle_entry();
        fetch_entry_t e;
        e.pc       = '0;
        e.instr    = NOP_INSTR;
        e.exc_en   = 1'b0;
        e.exc_code = '0;
        e.exc_val  = '0;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between fetch and decode with a single-cycle flush.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic             full_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: owns the PC, reads the combinational imem, and queues the
// fetched word or fetch exception for decode. Any exception halts fetch until redirect.
module instr_fetch
    import core_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] pc_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val
);

    logic [63:0]  pc_q, pc_d;
    logic         halted_q, halted_d;
    logic         q_empty, q_full;
    logic         pop;
    logic         slot;
    fetch_entry_t fetch_entry;
    fetch_entry_t head_entry;
    fetch_entry_t out_entry;

    assign pc_addr   = pc_q;
    assign out_valid = !q_empty;
    // Redirect wins over the handshake: nothing leaves the queue that cycle.
    assign pop       = out_valid && out_ready && !redirect_en;
    assign slot      = !redirect_en && !halted_q && (!q_full || pop);

    always_comb begin
        fetch_entry.pc       = pc_q;
        fetch_entry.instr    = imem_instr;
        fetch_entry.exc_en   = imem_exc_en;
        fetch_entry.exc_code = imem_exc_code;
        fetch_entry.exc_val  = imem_exc_val;
        // A misaligned PC is caught locally; imem's answer is irrelevant then.
        if (pc_q[1:0] != 2'b00) begin
            fetch_entry.exc_en   = 1'b1;
            fetch_entry.exc_code = EXC_INSTR_MISALIGNED;
            fetch_entry.exc_val  = pc_q;
        end
        if (fetch_entry.exc_en) begin
            fetch_entry.instr = NOP_INSTR;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (redirect_en) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
        end else if (slot) begin
            if (fetch_entry.exc_en) halted_d = 1'b1;
            else                    pc_d     = pc_q + 64'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fetch_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_en),
        .push_i      (slot),
        .push_data_i (fetch_entry),
        .pop_i       (pop),
        .empty_o     (q_empty),
        .full_o      (q_full),
        .head_o      (head_entry)
    );

    assign out_entry    = out_valid ? head_entry : idle_entry();
    assign out_instr    = out_entry.instr;
    assign out_pc       = out_entry.pc;
    assign out_exc_en   = out_entry.exc_en;
    assign out_exc_code = out_entry.exc_code;
    assign out_exc_val  = out_entry.exc_val;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a directed vector table walking the main scenarios,
// then randomized traffic compared against a queue-based reference model.
module tb_instr_fetch;
    import core_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [63:0] RPC   = 64'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_addr       (pc_addr),
        .imem_instr    (imem_instr),
        .imem_exc_en   (imem_exc_en),
        .imem_exc_code (imem_exc_code),
        .imem_exc_val  (imem_exc_val),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_exc_en    (out_exc_en),
        .out_exc_code  (out_exc_code),
        .out_exc_val   (out_exc_val)
    );

    int checks   = 0;
    int failures = 0;

    // Instruction memory contents; address 0 holds 32'h00500093.
    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'h0050_0093 ^ {a[25:2], 8'h00};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs; the imem answers for fetch address fa.
    task automatic apply(input bit r, input bit re, input logic [63:0] rpc, input bit rdy,
                         input bit iexc, input logic [3:0] icode, input logic [63:0] fa);
        rst           = r;
        redirect_en   = re;
        redirect_pc   = rpc;
        out_ready     = rdy;
        imem_instr    = instr_of(fa);
        imem_exc_en   = iexc;
        imem_exc_code = icode;
        imem_exc_val  = fa;
    endtask

    typedef struct {
        bit          rst;
        bit          re;
        logic [63:0] rpc;
        bit          rdy;
        bit          iexc;
        bit          dflt;
        bit          ev;
        logic [63:0] epc;
        bit          eexc;
        logic [3:0]  ecode;
        logic [63:0] eaddr;
    } vec_t;

    function automatic vec_t mk(bit r, bit re, logic [63:0] rpc, bit rdy, bit iexc, bit dflt,
                                bit ev, logic [63:0] epc, bit eexc, logic [3:0] ecode,
                                logic [63:0] eaddr);
        vec_t v;
        v.rst = r; v.re = re; v.rpc = rpc; v.rdy = rdy; v.iexc = iexc; v.dflt = dflt;
        v.ev = ev; v.epc = epc; v.eexc = eexc; v.ecode = ecode; v.eaddr = eaddr;
        return v;
    endfunction

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        bit          exc;
        logic [3:0]  code;
        logic [63:0] val;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    bit          m_halt;

    vec_t tbl[30];

    initial begin
        // rst re rpc rdy iexc dflt | valid head_pc exc code pc_addr
        tbl[0]  = mk(1, 0, 64'h0,    1, 0, 1, 0, 64'h0,    0, 4'd0, 64'h0);
        tbl[1]  = mk(0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    0, 4'd0, 64'h0);
        tbl[2]  = mk(0, 0, 64'h0,    1, 0, 0, 1, 64'h0,    0, 4'd0, 64'h4);
        tbl[3]  = mk(0, 0, 64'h0,    0, 0, 0, 1, 64'h4,    0, 4'd0, 64'h8);
        tbl[4]  = mk(0, 0, 64'h0,    0, 0, 0, 1, 64'h4,    0, 4'd0, 64'hc);
        tbl[5]  = mk(0, 0, 64'h0,    0, 0, 0, 1, 64'h4,    0, 4'd0, 64'hc);
        tbl[6]  = mk(0, 0, 64'h0,    0, 0, 0, 1, 64'h4,    0, 4'd0, 64'hc);
        tbl[7]  = mk(0, 0, 64'h0,    0, 0, 0, 1, 64'h4,    0, 4'd0, 64'hc);
        tbl[8]  = mk(0, 0, 64'h0,    1, 0, 0, 1, 64'h4,    0, 4'd0, 64'hc);
        tbl[9]  = mk(0, 0, 64'h0,    1, 0, 0, 1, 64'h8,    0, 4'd0, 64'h10);
        tbl[10] = mk(0, 1, 64'h100,  1, 0, 0, 1, 64'hc,    0, 4'd0, 64'h14);
        tbl[11] = mk(0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    0, 4'd0, 64'h100);
        tbl[12] = mk(0, 0, 64'h0,    1, 0, 0, 1, 64'h100,  0, 4'd0, 64'h104);
        tbl[13] = mk(0, 1, 64'h102,  1, 0, 0, 1, 64'h104,  0, 4'd0, 64'h108);
        tbl[14] = mk(0, 0, 64'h0,    0, 0, 0, 0, 64'h0,    0, 4'd0, 64'h102);
        tbl[15] = mk(0, 0, 64'h0,    0, 0, 0, 1, 64'h102,  1, 4'd0, 64'h102);
        tbl[16] = mk(0, 0, 64'h0,    1, 0, 0, 1, 64'h102,  1, 4'd0, 64'h102);
        tbl[17] = mk(0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    0, 4'd0, 64'h102);
        tbl[18] = mk(0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    0, 4'd0, 64'h102);
        tbl[19] = mk(0, 1, 64'h2000, 1, 0, 0, 0, 64'h0,    0, 4'd0, 64'h102);
        tbl[20] = mk(0, 0, 64'h0,    0, 1, 0, 0, 64'h0,    0, 4'd0, 64'h2000);
        tbl[21] = mk(0, 0, 64'h0,    0, 0, 0, 1, 64'h2000, 1, 4'd1, 64'h2000);
        tbl[22] = mk(0, 0, 64'h0,    1, 1, 0, 1, 64'h2000, 1, 4'd1, 64'h2000);
        tbl[23] = mk(0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    0, 4'd0, 64'h2000);
        tbl[24] = mk(0, 1, 64'h0,    1, 0, 0, 0, 64'h0,    0, 4'd0, 64'h2000);
        tbl[25] = mk(0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    0, 4'd0, 64'h0);
        tbl[26] = mk(0, 0, 64'h0,    1, 0, 0, 1, 64'h0,    0, 4'd0, 64'h4);
        tbl[27] = mk(0, 0, 64'h0,    0, 0, 0, 1, 64'h4,    0, 4'd0, 64'h8);
        tbl[28] = mk(1, 1, 64'h500,  1, 0, 0, 1, 64'h4,    0, 4'd0, 64'hc);
        tbl[29] = mk(0, 0, 64'h0,    0, 0, 0, 0, 64'h0,    0, 4'd0, 64'h0);

        apply(1, 0, 64'h0, 0, 0, 4'd1, 64'h0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            string tag;
            @(negedge clk);
            apply(tbl[i].rst, tbl[i].re, tbl[i].rpc, tbl[i].rdy, tbl[i].iexc, 4'd1, tbl[i].eaddr);
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, ".pc_addr"}, pc_addr, tbl[i].eaddr);
            chk({tag, ".valid"}, 64'(out_valid), 64'(tbl[i].ev));
            if (tbl[i].dflt) begin
                chk({tag, ".rst_instr"}, 64'(out_instr), 64'(NOP_INSTR));
                chk({tag, ".rst_pc"}, out_pc, 64'h0);
                chk({tag, ".rst_exc"}, 64'(out_exc_en), 64'h0);
                chk({tag, ".rst_code"}, 64'(out_exc_code), 64'h0);
                chk({tag, ".rst_val"}, out_exc_val, 64'h0);
            end
            if (tbl[i].ev) begin
                chk({tag, ".pc"}, out_pc, tbl[i].epc);
                chk({tag, ".exc"}, 64'(out_exc_en), 64'(tbl[i].eexc));
                chk({tag, ".instr"}, 64'(out_instr),
                    64'(tbl[i].eexc ? NOP_INSTR : instr_of(tbl[i].epc)));
                if (tbl[i].eexc) begin
                    chk({tag, ".code"}, 64'(out_exc_code), 64'(tbl[i].ecode));
                    chk({tag, ".val"}, out_exc_val, tbl[i].epc);
                end
            end
        end

        // Randomized traffic against the reference model.
        mq.delete();
        m_pc   = RPC;
        m_halt = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit          r, re, rdy, iexc, pop, can;
            logic [63:0] rpc;
            logic [3:0]  icode;
            ent_t        e;
            r     = (i == 0) || ($urandom_range(0, 199) == 0);
            re    = ($urandom_range(0, 19) == 0);
            rpc   = {40'h0, 22'($urandom), 2'b00};
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            rdy   = ($urandom_range(0, 9) < 6);
            iexc  = ($urandom_range(0, 29) == 0);
            icode = 4'($urandom_range(1, 7));
            @(negedge clk);
            apply(r, re, rpc, rdy, iexc, icode, m_pc);
            #1;
            if (i > 0) begin
                chk("rnd.pc_addr", pc_addr, m_pc);
                chk("rnd.valid", 64'(out_valid), 64'(mq.size() != 0));
                if (mq.size() != 0) begin
                    chk("rnd.pc", out_pc, mq[0].pc);
                    chk("rnd.instr", 64'(out_instr), 64'(mq[0].instr));
                    chk("rnd.exc", 64'(out_exc_en), 64'(mq[0].exc));
                    if (mq[0].exc) begin
                        chk("rnd.code", 64'(out_exc_code), 64'(mq[0].code));
                        chk("rnd.val", out_exc_val, mq[0].val);
                    end
                end
            end
            if (r) begin
                mq.delete();
                m_pc   = RPC;
                m_halt = 1'b0;
            end else if (re) begin
                mq.delete();
                m_pc   = rpc;
                m_halt = 1'b0;
            end else begin
                pop = (mq.size() != 0) && rdy;
                can = !m_halt && ((mq.size() < DEPTH) || pop);
                if (pop) void'(mq.pop_front());
                if (can) begin
                    e.pc = m_pc;
                    if (m_pc[1:0] != 2'b00) begin
                        e.exc = 1'b1; e.code = EXC_INSTR_MISALIGNED; e.val = m_pc;
                    end else begin
                        e.exc = iexc; e.code = icode; e.val = m_pc;
                    end
                    e.instr = e.exc ? NOP_INSTR : instr_of(m_pc);
                    mq.push_back(e);
                    if (e.exc) m_halt = 1'b1;
                    else       m_pc   = m_pc + 64'd4;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Front-end fetch unit for the RV64 core: owns the program counter, drives the instruction-memory read address, and captures the returned instruction word and any fetch exception into a small queue for the decode stage. It is the requester side of the imem read interface; the memory is combinational (address in, word/exception out in the same cycle). Branch/trap redirects flush in-flight state and restart fetch at a new target.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC loaded on reset
- FQ_DEPTH, 2, fetch queue entries (power of two, ≥2)

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pc_addr  output  64  fetch address to imem (combinational from PC register)
- imem_instr  input  32  instruction word returned for pc_addr
- imem_exc_en  input  1  imem fetch fault for pc_addr
- imem_exc_code  input  4  fault cause (1 = instruction access fault)
- imem_exc_val  input  64  faulting address
- redirect_en  input  1  flush and restart fetch (branch taken / trap / mret)
- redirect_pc  input  64  restart target
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_instr  output  32  head instruction (32'h00000013 when head is an exception)
- out_pc  output  64  head PC
- out_exc_en  output  1  head carries a fetch exception
- out_exc_code  output  4  head cause
- out_exc_val  output  64  head tval

## Operation
- State: pc (64), queue (FQ_DEPTH × {pc, instr, exc_en, code, val}), count, halted flag.
- Fetch slot: taken in a cycle when !rst, !redirect_en, !halted, and (count < FQ_DEPTH or dequeue this cycle). Slot enqueues {pc, imem fields} and sets pc ← pc + 4 (64-bit wrap, no overflow flag).
- Local misalignment check: if pc[1:0] ≠ 0 during a fetch slot, enqueue exception code 0 (instruction address misaligned), val = pc, instr = NOP; imem fields ignored.
- Any enqueued exception sets halted; pc is not advanced. While halted, no further fetches, irrespective of imem_exc_en toggling. Only redirect or reset clears halted.
- Dequeue: out_valid && out_ready pops head. Head fields stable while out_valid && !out_ready.
- Redirect (priority over everything except rst): queue emptied, count ← 0, halted ← 0, pc ← redirect_pc; no enqueue and no dequeue that cycle (out_ready ignored).
- Simultaneous full queue + dequeue: enqueue allowed same cycle (count unchanged).
- pc_addr = pc at all times, including reset.

## Timing
- Reset values (next edge with rst=1): pc = RESET_PC, count = 0, halted = 0; out_valid = 0, out_exc_en = 0, out_instr = 32'h00000013, out_pc/out_exc_val = 0, out_exc_code = 0.
- First out_valid: cycle after the first cycle with rst = 0 (1-cycle fetch-to-decode latency).
- Redirect asserted in cycle N: out_valid = 0 in N+1; instruction at redirect_pc valid in N+2.
- Sustained throughput: one instruction per cycle with out_ready held high.
- Reset mid-operation overrides redirect and handshake; queue contents discarded.

## Structure
- Shared package (core_pkg): EXC_INSTR_MISALIGNED = 4'd0, EXC_INSTR_ACCESS_FAULT = 4'd1, NOP_INSTR = 32'h00000013, fetch-entry field widths.
- Sub-module fetch_queue: synchronous FIFO with flush, push/pop, full/empty, head-output registers; parameterized by depth and entry width. instr_fetch holds PC, halt, and slot logic.

## Test plan
- Reset release, out_ready = 1, imem returns 32'h00500093 at 0x0 → out_valid in cycle 1 with out_pc = 0x0, then 0x4, 0x8 on consecutive cycles.
- out_ready = 0 for 5 cycles → exactly FQ_DEPTH entries captured, pc_addr frozen at RESET_PC + 4·FQ_DEPTH, head fields stable; release → in-order drain with no gaps or duplicates.
- Redirect to 0x100 while queue full → cycle N+1 out_valid = 0; N+2 out_pc = 0x100; no stale entries emerge.
- Redirect to 0x102 → single entry exc_en = 1, code 0, val 0x102, instr NOP; then no further fetches until next redirect.
- imem_exc_en = 1 (code 1, val 0x2000) at pc 0x2000, then imem deasserts next cycle → exactly one exception entry, fetch halted; redirect to 0x0 resumes normal fetch.
- rst asserted concurrently with redirect_en and full queue → next cycle pc_addr = RESET_PC, out_valid = 0.
